// File: rtl/z80_bus_responder.sv
// Synthesizable RAM/IO target for the tv80s Z80 bus with programmable wait states.
// Optional write protection of the low ROM region is built when Z80_RESP_WP_EN is defined.
module z80_bus_responder #(
  parameter int          ADDR_W      = 16,
  parameter logic [7:0]  IO_PAGE     = 8'h10,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [7:0]  INT_VECTOR  = 8'hFF,
  parameter logic [15:0] ROM_TOP     = 16'h0FFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] A,
  input  logic [7:0]  cpu_do,
  input  logic        m1_n,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        rfsh_n,
  output logic [7:0]  di,
  output logic        wait_n,
  output logic        wp_hit
);

`ifdef Z80_RESP_WP_EN
  localparam bit WP_EN = 1'b1;
`else
  localparam bit WP_EN = 1'b0;
`endif

  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_HOLD} state_t;
  typedef enum logic [1:0] {K_READ, K_WRITE, K_INTACK} kind_t;

  state_t            state;
  kind_t             kind_q;
  logic [3:0]        cnt;
  logic              blocked_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        data_q;
  logic [7:0]        mem [2**ADDR_W];

  logic              intack_req, mem_req, io_req, any_req, blocked_d, bus_idle, ram_we;
  logic [15:0]       io_full;
  logic [ADDR_W-1:0] req_addr;
  kind_t             req_kind;

  assign intack_req = !iorq_n && !m1_n;
  assign mem_req    = !mreq_n && rfsh_n && (!rd_n || !wr_n);
  assign io_req     = !iorq_n && m1_n && (!rd_n || !wr_n);
  assign any_req    = intack_req || mem_req || io_req;

  assign io_full  = {IO_PAGE, A[7:0]};
  assign req_addr = mem_req ? A[ADDR_W-1:0] : io_full[ADDR_W-1:0];
  assign req_kind = intack_req ? K_INTACK : (!wr_n ? K_WRITE : K_READ);

  // Only memory writes are protected; an IO write is never blocked even with a low A.
  assign blocked_d = WP_EN && !intack_req && mem_req && !wr_n && (A <= ROM_TOP);

  // An interrupt acknowledge carries no rd/wr strobe, so it ends when iorq_n or m1_n rises.
  assign bus_idle = (kind_q == K_INTACK) ? (iorq_n || m1_n)
                                         : ((mreq_n && iorq_n) || (rd_n && wr_n));

  assign ram_we = (state == S_ACCESS) && (kind_q == K_WRITE) && !blocked_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      kind_q    <= K_READ;
      cnt       <= 4'd0;
      blocked_q <= 1'b0;
      di        <= 8'hFF;
      wait_n    <= 1'b1;
      wp_hit    <= 1'b0;
    end else begin
      wp_hit <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            kind_q    <= req_kind;
            blocked_q <= blocked_d;
            if (WAIT_CYCLES > 0) begin
              state  <= S_WAIT;
              wait_n <= 1'b0;
              cnt    <= WAIT_INIT;
            end else begin
              state <= S_ACCESS;
            end
          end
        end
        S_WAIT: begin
          if (bus_idle) begin
            state  <= S_IDLE;
            wait_n <= 1'b1;
          end else if (cnt == 4'd0) begin
            state  <= S_ACCESS;
            wait_n <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_ACCESS: begin
          case (kind_q)
            K_READ:   di     <= mem[addr_q];
            K_INTACK: di     <= INT_VECTOR;
            default:  wp_hit <= blocked_q;
          endcase
          state <= S_HOLD;
        end
        default: begin
          if (bus_idle) state <= S_IDLE;
        end
      endcase
    end
  end

  // Address and write data are frozen at detection so later bus changes cannot leak in.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && any_req) begin
      addr_q <= req_addr;
      data_q <= cpu_do;
    end
    if (ram_we) mem[addr_q] <= data_q;
  end

endmodule
